// File: rtl/scoreboard_regfile_if.sv
// Decode-side bundle for scoreboard_regfile: issue request, writeback ports and operand/status outputs.
// Handshake: an issue is taken on a posedge where I_LOCK & I_IssueValid & !O_DepStall (O_IssueAccept=1); there is no back-pressure on writebacks.
interface scoreboard_regfile_if #(
    parameter int IDX_WIDTH = 4,
    parameter int REG_WIDTH = 32,
    parameter int NUM_WB    = 2
);
    logic                          I_LOCK;
    logic                          I_IssueValid;
    logic                          I_Src1En;
    logic                          I_Src2En;
    logic [IDX_WIDTH-1:0]          I_Src1Idx;
    logic [IDX_WIDTH-1:0]          I_Src2Idx;
    logic                          I_DestEn;
    logic [IDX_WIDTH-1:0]          I_DestIdx;
    logic [NUM_WB-1:0]             I_WbEnable;
    logic [NUM_WB*IDX_WIDTH-1:0]   I_WbIdx;
    logic [NUM_WB*REG_WIDTH-1:0]   I_WbData;
    logic                          O_DepStall;
    logic                          O_IssueAccept;
    logic                          O_Valid;
    logic [REG_WIDTH-1:0]          O_Src1Value;
    logic [REG_WIDTH-1:0]          O_Src2Value;
    logic [2:0]                    O_CC;
    logic                          O_AnyPending;
    logic                          O_ScoreboardError;

    modport master (
        output I_LOCK, I_IssueValid, I_Src1En, I_Src2En, I_Src1Idx, I_Src2Idx,
               I_DestEn, I_DestIdx, I_WbEnable, I_WbIdx, I_WbData,
        input  O_DepStall, O_IssueAccept, O_Valid, O_Src1Value, O_Src2Value,
               O_CC, O_AnyPending, O_ScoreboardError
    );

    modport slave (
        input  I_LOCK, I_IssueValid, I_Src1En, I_Src2En, I_Src1Idx, I_Src2Idx,
               I_DestEn, I_DestIdx, I_WbEnable, I_WbIdx, I_WbData,
        output O_DepStall, O_IssueAccept, O_Valid, O_Src1Value, O_Src2Value,
               O_CC, O_AnyPending, O_ScoreboardError
    );
endinterface

// File: rtl/scoreboard_regfile.sv
// Decode-stage register file with per-register pending-write counters, N writeback ports
// and same-cycle writeback bypass to the operand outputs.
module scoreboard_regfile #(
    parameter int NUM_REGS   = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int REG_WIDTH  = 32,
    parameter int NUM_WB     = 2,
    parameter int PEND_WIDTH = 2
) (
    input logic                  I_CLOCK,
    input logic                  I_RESET,
    scoreboard_regfile_if.slave  bus
);
    localparam logic [PEND_WIDTH-1:0] PMAX = '1;

    logic [REG_WIDTH-1:0]  rf_q   [NUM_REGS];
    logic [REG_WIDTH-1:0]  rf_d   [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
    logic                  valid_q, valid_d;
    logic [REG_WIDTH-1:0]  src1_q, src1_d, src2_q, src2_d;
    logic [2:0]            cc_q, cc_d;
    logic                  err_q, err_d;

    logic                  s1_hit, s2_hit, s1_rdy, s2_rdy, dest_blk;
    logic [REG_WIDTH-1:0]  s1_byp, s2_byp, wbd;
    logic                  dep_stall, accept, any_pend;
    int unsigned           dec_v, inc_v, sum_v;

    // Bypass: ascending scan, so the highest-numbered matching port wins.
    always_comb begin
        s1_hit = 1'b0;
        s2_hit = 1'b0;
        s1_byp = '0;
        s2_byp = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (bus.I_WbEnable[k] && bus.I_WbIdx[k*IDX_WIDTH +: IDX_WIDTH] == bus.I_Src1Idx) begin
                s1_hit = 1'b1;
                s1_byp = bus.I_WbData[k*REG_WIDTH +: REG_WIDTH];
            end
            if (bus.I_WbEnable[k] && bus.I_WbIdx[k*IDX_WIDTH +: IDX_WIDTH] == bus.I_Src2Idx) begin
                s2_hit = 1'b1;
                s2_byp = bus.I_WbData[k*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // A bypass can only retire the last outstanding write; pend>=2 always stalls.
    assign s1_rdy = !bus.I_Src1En || pend_q[bus.I_Src1Idx] == '0 ||
                    (pend_q[bus.I_Src1Idx] == PEND_WIDTH'(1) && s1_hit);
    assign s2_rdy = !bus.I_Src2En || pend_q[bus.I_Src2Idx] == '0 ||
                    (pend_q[bus.I_Src2Idx] == PEND_WIDTH'(1) && s2_hit);
    assign dest_blk  = bus.I_DestEn && pend_q[bus.I_DestIdx] == PMAX;
    assign dep_stall = bus.I_LOCK && bus.I_IssueValid && (!s1_rdy || !s2_rdy || dest_blk);
    assign accept    = bus.I_LOCK && bus.I_IssueValid && !dep_stall && !I_RESET;

    always_comb begin
        any_pend = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (pend_q[r] != '0) any_pend = 1'b1;
        end
    end

    always_comb begin
        rf_d    = rf_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        cc_d    = cc_q;
        err_d   = err_q;
        dec_v   = 0;
        inc_v   = 0;
        sum_v   = 0;
        wbd     = '0;
        if (bus.I_LOCK) begin
            valid_d = accept;
            if (accept) begin
                src1_d = !bus.I_Src1En ? '0 : (s1_hit ? s1_byp : rf_q[bus.I_Src1Idx]);
                src2_d = !bus.I_Src2En ? '0 : (s2_hit ? s2_byp : rf_q[bus.I_Src2Idx]);
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                dec_v = 0;
                for (int k = 0; k < NUM_WB; k++) begin
                    if (bus.I_WbEnable[k] && bus.I_WbIdx[k*IDX_WIDTH +: IDX_WIDTH] == IDX_WIDTH'(r)) begin
                        rf_d[r] = bus.I_WbData[k*REG_WIDTH +: REG_WIDTH];
                        dec_v   = dec_v + 1;
                    end
                end
                inc_v = (accept && bus.I_DestEn && bus.I_DestIdx == IDX_WIDTH'(r)) ? 1 : 0;
                sum_v = 32'(pend_q[r]) + inc_v;
                // Retiring more writes than are outstanding is a producer bug: clamp and flag.
                if (sum_v < dec_v) begin
                    pend_d[r] = '0;
                    err_d     = 1'b1;
                end else begin
                    pend_d[r] = PEND_WIDTH'(sum_v - dec_v);
                end
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if (bus.I_WbEnable[k]) begin
                    wbd = bus.I_WbData[k*REG_WIDTH +: REG_WIDTH];
                    if (wbd[REG_WIDTH-1])  cc_d = 3'b100;
                    else if (wbd == '0)    cc_d = 3'b010;
                    else                   cc_d = 3'b001;
                end
            end
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf_q[r]   <= '0;
                pend_q[r] <= '0;
            end
            valid_q <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            cc_q    <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            rf_q    <= rf_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            cc_q    <= cc_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_DepStall        = dep_stall;
    assign bus.O_IssueAccept     = accept;
    assign bus.O_Valid           = valid_q;
    assign bus.O_Src1Value       = src1_q;
    assign bus.O_Src2Value       = src2_q;
    assign bus.O_CC              = cc_q;
    assign bus.O_AnyPending      = any_pend;
    assign bus.O_ScoreboardError = err_q;
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: linear issue/writeback sequence with hand-computed expectations.
module tb_scoreboard_regfile;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  scoreboard_regfile_if #(.IDX_WIDTH(4), .REG_WIDTH(32), .NUM_WB(2)) bus ();

  scoreboard_regfile #(
    .NUM_REGS(16), .IDX_WIDTH(4), .REG_WIDTH(32), .NUM_WB(2), .PEND_WIDTH(2)
  ) dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.I_LOCK       = 1'b1;
    bus.I_IssueValid = 1'b0;
    bus.I_Src1En     = 1'b0;
    bus.I_Src2En     = 1'b0;
    bus.I_Src1Idx    = '0;
    bus.I_Src2Idx    = '0;
    bus.I_DestEn     = 1'b0;
    bus.I_DestIdx    = '0;
    bus.I_WbEnable   = '0;
    bus.I_WbIdx      = '0;
    bus.I_WbData     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit s1e, input int s1, input bit s2e, input int s2, input bit de, input int d);
    bus.I_IssueValid = 1'b1;
    bus.I_Src1En     = s1e;
    bus.I_Src1Idx    = 4'(s1);
    bus.I_Src2En     = s2e;
    bus.I_Src2Idx    = 4'(s2);
    bus.I_DestEn     = de;
    bus.I_DestIdx    = 4'(d);
  endtask

  task automatic wb(input int k, input int idx, input logic [31:0] data);
    bus.I_WbEnable[k]      = 1'b1;
    bus.I_WbIdx[k*4 +: 4]  = 4'(idx);
    bus.I_WbData[k*32 +: 32] = data;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 32'(bus.O_Valid), 0);
    chk("rst_src1", bus.O_Src1Value, 0);
    chk("rst_src2", bus.O_Src2Value, 0);
    chk("rst_cc", 32'(bus.O_CC), 0);
    chk("rst_err", 32'(bus.O_ScoreboardError), 0);
    chk("rst_anypend", 32'(bus.O_AnyPending), 0);

    // 1: plain read issue, then a writer of R5
    issue(1, 2, 1, 3, 0, 0);
    #1;
    chk("t1_stall", 32'(bus.O_DepStall), 0);
    chk("t1_accept", 32'(bus.O_IssueAccept), 1);
    step();
    chk("t1_valid", 32'(bus.O_Valid), 1);
    chk("t1_src1", bus.O_Src1Value, 0);
    chk("t1_src2", bus.O_Src2Value, 0);
    issue(0, 0, 0, 0, 1, 5);
    #1;
    chk("t1_dest_accept", 32'(bus.O_IssueAccept), 1);
    step();
    idle();
    #1;
    chk("t1_anypend", 32'(bus.O_AnyPending), 1);

    // 2: reader of R5 stalls, then is released by a same-cycle bypass
    issue(1, 5, 0, 0, 0, 0);
    #1;
    chk("t2_stall", 32'(bus.O_DepStall), 1);
    chk("t2_noaccept", 32'(bus.O_IssueAccept), 0);
    step();
    chk("t2_valid_low", 32'(bus.O_Valid), 0);
    wb(0, 5, 32'h0000_0007);
    #1;
    chk("t2_bypass_stall", 32'(bus.O_DepStall), 0);
    step();
    idle();
    #1;
    chk("t2_valid", 32'(bus.O_Valid), 1);
    chk("t2_src1_byp", bus.O_Src1Value, 32'h7);
    chk("t2_src2_off", bus.O_Src2Value, 0);
    chk("t2_cc", 32'(bus.O_CC), 3'b001);
    chk("t2_anypend", 32'(bus.O_AnyPending), 0);

    // 3: three writers of R1 saturate the counter; a fourth waits for one retirement
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 0, 0, 1, 1);
      #1;
      chk("t3_writer_accept", 32'(bus.O_IssueAccept), 1);
      step();
    end
    #1;
    chk("t3_full_stall", 32'(bus.O_DepStall), 1);
    step();
    chk("t3_still_stall", 32'(bus.O_DepStall), 1);
    wb(0, 1, 32'h0);
    #1;
    chk("t3_no_wb_credit", 32'(bus.O_DepStall), 1);
    step();
    idle();
    issue(0, 0, 0, 0, 1, 1);
    #1;
    chk("t3_cc_zero", 32'(bus.O_CC), 3'b010);
    chk("t3_release", 32'(bus.O_IssueAccept), 1);
    step();
    idle();
    wb(0, 1, 32'h10);
    wb(1, 1, 32'h20);
    step();
    idle();
    wb(0, 1, 32'h30);
    step();
    idle();
    #1;
    chk("t3_drained", 32'(bus.O_AnyPending), 0);
    chk("t3_err_clear", 32'(bus.O_ScoreboardError), 0);
    issue(1, 1, 0, 0, 0, 0);
    step();
    idle();
    chk("t3_r1_value", bus.O_Src1Value, 32'h30);

    // 4: two writers of R4, both ports retire them in one cycle
    issue(0, 0, 0, 0, 1, 4);
    step();
    step();
    idle();
    wb(0, 4, 32'h5);
    wb(1, 4, 32'hFFFF_FFFF);
    issue(1, 4, 0, 0, 0, 0);
    #1;
    chk("t4_pend2_no_bypass", 32'(bus.O_DepStall), 1);
    step();
    idle();
    #1;
    chk("t4_anypend", 32'(bus.O_AnyPending), 0);
    chk("t4_cc_neg", 32'(bus.O_CC), 3'b100);
    chk("t4_err", 32'(bus.O_ScoreboardError), 0);
    issue(0, 0, 1, 4, 0, 0);
    step();
    idle();
    chk("t4_r4_src2", bus.O_Src2Value, 32'hFFFF_FFFF);
    chk("t4_src1_off", bus.O_Src1Value, 0);

    // same-cycle bypass picks the highest-numbered port
    issue(0, 0, 0, 0, 1, 6);
    step();
    idle();
    issue(1, 6, 0, 0, 0, 0);
    wb(0, 6, 32'hAAAA);
    wb(1, 6, 32'hBBBB);
    step();
    idle();
    chk("t4_byp_hi_port", bus.O_Src1Value, 32'hBBBB);

    // 5: writeback to a register with nothing pending sets the sticky error
    chk("t5_err_before", 32'(bus.O_ScoreboardError), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_err_reset", 32'(bus.O_ScoreboardError), 0);
    wb(1, 9, 32'h99);
    step();
    idle();
    chk("t5_err_set", 32'(bus.O_ScoreboardError), 1);
    issue(1, 9, 0, 0, 0, 0);
    step();
    idle();
    step();
    chk("t5_r9_value", bus.O_Src1Value, 32'h99);
    chk("t5_err_sticky", 32'(bus.O_ScoreboardError), 1);

    // 6: reset with pending writers and an active writeback
    issue(0, 0, 0, 0, 1, 5);
    step();
    step();
    idle();
    #1;
    chk("t6_pending", 32'(bus.O_AnyPending), 1);
    rst = 1'b1;
    wb(0, 5, 32'h55);
    issue(1, 2, 0, 0, 0, 0);
    #1;
    chk("t6_rst_noaccept", 32'(bus.O_IssueAccept), 0);
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("t6_anypend", 32'(bus.O_AnyPending), 0);
    chk("t6_valid", 32'(bus.O_Valid), 0);
    chk("t6_cc", 32'(bus.O_CC), 0);
    chk("t6_err", 32'(bus.O_ScoreboardError), 0);
    issue(1, 5, 1, 4, 0, 0);
    step();
    idle();
    chk("t6_r5_cleared", bus.O_Src1Value, 0);
    chk("t6_r4_cleared", bus.O_Src2Value, 0);
    chk("t6_valid_read", 32'(bus.O_Valid), 1);

    // I_LOCK=0: issue and writeback ignored, everything holds
    bus.I_LOCK = 1'b0;
    issue(1, 5, 0, 0, 1, 6);
    wb(0, 5, 32'h77);
    #1;
    chk("t6_lock_stall", 32'(bus.O_DepStall), 0);
    chk("t6_lock_accept", 32'(bus.O_IssueAccept), 0);
    step();
    step();
    chk("t6_lock_valid_hold", 32'(bus.O_Valid), 1);
    chk("t6_lock_cc_hold", 32'(bus.O_CC), 0);
    chk("t6_lock_nopend", 32'(bus.O_AnyPending), 0);
    idle();
    issue(1, 5, 0, 0, 0, 0);
    step();
    idle();
    chk("t6_lock_no_write", bus.O_Src1Value, 0);
    chk("t6_lock_err", 32'(bus.O_ScoreboardError), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
- Parametrised register file plus counting scoreboard for the decode stage.
- Successor to the single-valid-bit decode register file:
  - N writeback ports
  - per-register pending-write counters, so multiple in-flight writers (WAW) are legal
  - same-cycle writeback bypass
  - single-edge (posedge) timing
  - synchronous reset
- Sits between fetch/decode issue logic and the execute stage. Writeback stages feed it directly.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- IDX_WIDTH, 4, register index width (2^IDX_WIDTH >= NUM_REGS).
- REG_WIDTH, 32, register data width.
- NUM_WB, 2, number of writeback ports.
- PEND_WIDTH, 2, pending-counter width; PMAX = 2^PEND_WIDTH-1 outstanding writes per register.

Ports:
- I_CLOCK  in  1  clock; all state changes on posedge.
- I_RESET  in  1  synchronous, active-high reset.
- I_LOCK  in  1  global enable. When 0: no state change, outputs hold.
- I_IssueValid  in  1  decode presents an instruction.
- I_Src1En, I_Src2En  in  1 each  source operand used.
- I_Src1Idx, I_Src2Idx  in  IDX_WIDTH each  source register indices.
- I_DestEn  in  1  instruction writes a register.
- I_DestIdx  in  IDX_WIDTH  destination index.
- I_WbEnable  in  NUM_WB  per-port writeback enable.
- I_WbIdx  in  NUM_WB*IDX_WIDTH  packed indices; port k at [k*IDX_WIDTH +: IDX_WIDTH].
- I_WbData  in  NUM_WB*REG_WIDTH  packed data; port k at [k*REG_WIDTH +: REG_WIDTH].
- O_DepStall  out  1  combinational: issue blocked this cycle.
- O_IssueAccept  out  1  combinational: I_LOCK & I_IssueValid & !O_DepStall & !I_RESET.
- O_Valid  out  1  registered: operands below belong to an accepted instruction.
- O_Src1Value, O_Src2Value  out  REG_WIDTH each  registered operand values.
- O_CC  out  3  condition code {N,Z,P} of the last retired writeback.
- O_AnyPending  out  1  combinational: OR of all pending counters != 0 (branch-stall hook).
- O_ScoreboardError  out  1  sticky: writeback seen to a register with pending count 0.

Behaviour:
- Reset (posedge with I_RESET=1) clears:
  - all RF entries and pending counters to 0
  - O_Valid, O_Src1Value, O_Src2Value to 0
  - O_CC to 3'b000 and O_ScoreboardError to 0
- Writeback ports active in the reset cycle are ignored.
- Source readiness, per enabled source s:
  - ready if pend[s]==0
  - ready if pend[s]==1 and at least one WB port writes s this cycle (bypass)
  - otherwise not ready
  - pend[s]>=2 is never ready, even with a bypass.
- Dest blocking: blocked if I_DestEn and pend[dest]==PMAX. No credit is taken for a same-cycle writeback.
- O_DepStall = I_LOCK & I_IssueValid & (any enabled source not ready | dest blocked).
- Disabled sources and dest are never checked.
- On accept (posedge), latency is 1 cycle:
  - O_Valid <= 1.
  - O_SrcN <= bypass value if any WB port matches; else RF[idx]; 0 if SrcEn=0.
  - pend[dest] increments.
- Non-accept posedge with I_LOCK=1: O_Valid <= 0, operand outputs hold.
- Writeback, per port k with I_WbEnable[k] and I_LOCK=1, at posedge:
  - RF[idx_k] <= data_k.
  - pend[idx_k] decrements.
- Multiple ports, same index, same cycle:
  - RF takes the highest-numbered port's data.
  - the bypass also selects the highest-numbered matching port.
  - the counter decrements once per port.
- Net counter update: pend_next = pend + inc - dec_count.
  - Saturates at 0; an underflow attempt sets O_ScoreboardError and leaves the counter at 0.
  - Issue logic guarantees it never exceeds PMAX.
- A same-cycle issue to dest r plus a writeback to r gives a net counter change of inc - dec. The RF still takes the WB data.
- O_CC updates from the highest-numbered enabled port each cycle any WB is active, on signed data:
  - >0 gives 3'b001
  - <0 gives 3'b100
  - ==0 gives 3'b010
- O_CC holds otherwise.
- I_LOCK=0: writebacks and issues are ignored, all registers hold, O_DepStall=0, O_IssueAccept=0.

Test Plan:
1. Reset, then issue with Src1=R2 and Src2=R3 -> stall 0, next cycle O_Valid=1 with both operands 0. Issue with DestIdx=R5 -> pend[5]=1, O_AnyPending=1.
2. After issuing dest R5, issue a reader of R5 -> O_DepStall=1. Next cycle, WB port0 writes R5=32'h0000_0007 while the reader is held -> accept, O_Src1Value=7 the following cycle (bypass), pend[5]=0, O_CC=3'b001.
3. PEND_WIDTH=2: issue three writers of R1 -> pend[1]=3. Fourth writer -> O_DepStall=1 until one WB to R1.
4. Ports 0 and 1 both write R4 (data 5 and 32'hFFFF_FFFF) with pend[4]=2 -> RF[4]=32'hFFFF_FFFF, pend[4]=0, O_CC=3'b100.
5. WB to R9 with pend[9]=0 -> RF[9] written, O_ScoreboardError=1 and stays 1 until reset.
6. Assert I_RESET with pend[5]=2 while a WB to R5 is active -> all counters 0, RF[5]=0, O_Valid=0, O_CC=3'b000. Hold I_LOCK=0 with an issue and a WB -> no state change.
